output_link_tx: RTL and testbench

//  Output-port link transmitter. Accepts flits leaving the crossbar, buffers them per VC,
//  and drives the inter-router link into the downstream router's input VC buffer.

---
 rtl/noc_pkg.sv | 13 +
 rtl/vc_out_fifo.sv | 53 +++++
 rtl/output_link_tx.sv | 130 +++++++++++++
 tb/tb_output_link_tx.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC constants used by the output link, input buffer and crossbar.
package noc_pkg;
    localparam int FLIT_W   = 64;
    localparam int NUM_VC   = 2;
    localparam int VC_ID_W  = 2;
    localparam int VC_DEPTH = 2;
    localparam int TXCNT_W  = 16;

    // Occupancy counter width for a queue of the given depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/vc_out_fifo.sv
// One per-VC circular output queue. The caller never writes when full,
// except alongside a read, where the net occupancy stays the same.
import noc_pkg::*;

module vc_out_fifo #(
    parameter int DATA_W = FLIT_W,
    parameter int DEPTH  = VC_DEPTH,
    parameter int CNT_W  = cnt_w(VC_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic [CNT_W-1:0]  count
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] r_mem;
    logic [PTR_W-1:0]             r_wr_ptr;
    logic [PTR_W-1:0]             r_rd_ptr;
    logic [CNT_W-1:0]             r_count;

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clk) begin
        if (wr_en) r_mem[r_wr_ptr] <= wr_data;
    end

    // Pointer and occupancy update; power-of-2 depth makes the wrap free.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (wr_en) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (rd_en) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({wr_en, rd_en})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign empty = (r_count == '0);
    assign full  = (r_count == CNT_W'(DEPTH));
    assign count = r_count;
endmodule

// File: rtl/output_link_tx.sv
// Output-port link transmitter: per-VC queues, round-robin VC arbiter gated by
// downstream not-full status, drop reporting and a wrapping sent-flit counter.
import noc_pkg::*;

module output_link_tx #(
    parameter int FLIT_W  = noc_pkg::FLIT_W,
    parameter int NUM_VC  = noc_pkg::NUM_VC,
    parameter int VC_ID_W = noc_pkg::VC_ID_W,
    parameter int Q_DEPTH = noc_pkg::VC_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FLIT_W-1:0]  in_flit,
    input  logic [VC_ID_W-1:0] in_vc,
    input  logic               in_valid,
    output logic [NUM_VC-1:0]  in_vc_ready,
    output logic [FLIT_W-1:0]  tx_flit,
    output logic [VC_ID_W-1:0] tx_vc,
    output logic               tx_valid,
    input  logic [NUM_VC-1:0]  ds_vc_status,
    output logic               err_drop,
    output logic [15:0]        tx_count
);
    localparam int CNT_W = cnt_w(Q_DEPTH);

    logic [NUM_VC-1:0][FLIT_W-1:0] w_head;
    logic [NUM_VC-1:0][CNT_W-1:0]  w_count;
    logic [NUM_VC-1:0]             w_empty;
    logic [NUM_VC-1:0]             w_full;
    logic [NUM_VC-1:0]             w_wr_en;
    logic [NUM_VC-1:0]             w_rd_en;
    logic [NUM_VC-1:0]             w_elig;
    logic [VC_ID_W-1:0]            w_sel;
    logic                          w_tx_valid;
    logic                          w_vc_ok;
    logic                          w_tgt_ready;
    logic                          w_drop;
    logic                          w_unused_cnt;

    logic [VC_ID_W-1:0]            r_last_vc;
    logic                          r_err_drop;
    logic [15:0]                   r_tx_count;

    // Occupancy is exported by each queue for observability only.
    assign w_unused_cnt = ^w_count;

    assign w_vc_ok     = (in_vc < VC_ID_W'(NUM_VC));
    assign in_vc_ready = ~w_full;
    assign w_elig      = ~w_empty & ds_vc_status;
    assign w_tx_valid  = |w_elig;

    // Ready bit of the targeted VC; out-of-range ids match no VC.
    always_comb begin
        w_tgt_ready = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (in_vc == VC_ID_W'(v)) w_tgt_ready = in_vc_ready[v];
        end
    end

    assign w_drop = in_valid & (~w_vc_ok | ~w_tgt_ready);

    genvar g;
    generate
        for (g = 0; g < NUM_VC; g++) begin : g_vc
            assign w_wr_en[g] = in_valid & w_vc_ok & w_tgt_ready & (in_vc == VC_ID_W'(g));
            assign w_rd_en[g] = w_tx_valid & (w_sel == VC_ID_W'(g));

            vc_out_fifo #(
                .DATA_W (FLIT_W),
                .DEPTH  (Q_DEPTH),
                .CNT_W  (CNT_W)
            ) u_fifo (
                .clk     (clk),
                .rst     (rst),
                .wr_en   (w_wr_en[g]),
                .wr_data (in_flit),
                .rd_en   (w_rd_en[g]),
                .head    (w_head[g]),
                .empty   (w_empty[g]),
                .full    (w_full[g]),
                .count   (w_count[g])
            );
        end
    endgenerate

    // Round-robin pick: first eligible VC strictly after the last one served.
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        w_sel = '0;
        for (int i = 1; i <= NUM_VC; i++) begin
            idx = (int'(r_last_vc) + i) % NUM_VC;
            if (!found && w_elig[idx]) begin
                found = 1'b1;
                w_sel = VC_ID_W'(idx);
            end
        end
    end

    // Link output mux; an idle link drives zeros.
    always_comb begin
        tx_flit = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (w_tx_valid && w_sel == VC_ID_W'(v)) tx_flit = w_head[v];
        end
    end

    assign tx_vc    = w_tx_valid ? w_sel : '0;
    assign tx_valid = w_tx_valid;

    // Arbiter history, drop pulse and sent-flit counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_vc  <= VC_ID_W'(NUM_VC - 1);
            r_err_drop <= 1'b0;
            r_tx_count <= '0;
        end else begin
            r_err_drop <= w_drop;
            if (w_tx_valid) begin
                r_last_vc  <= w_sel;
                r_tx_count <= r_tx_count + 16'd1;
            end
        end
    end

    assign err_drop = r_err_drop;
    assign tx_count = r_tx_count;
endmodule

// File: tb/tb_output_link_tx.sv
// Directed bench for output_link_tx with a scoreboard queue and an
// independent link monitor that pops and compares every sent flit.
module tb_output_link_tx;
    logic        clk;
    logic        rst;
    logic [63:0] in_flit;
    logic [1:0]  in_vc;
    logic        in_valid;
    logic [1:0]  in_vc_ready;
    logic [63:0] tx_flit;
    logic [1:0]  tx_vc;
    logic        tx_valid;
    logic [1:0]  ds_vc_status;
    logic        err_drop;
    logic [15:0] tx_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  vc;
        logic [63:0] flit;
    } exp_t;
    exp_t sb[$];

    output_link_tx dut (
        .clk          (clk),
        .rst          (rst),
        .in_flit      (in_flit),
        .in_vc        (in_vc),
        .in_valid     (in_valid),
        .in_vc_ready  (in_vc_ready),
        .tx_flit      (tx_flit),
        .tx_vc        (tx_vc),
        .tx_valid     (tx_valid),
        .ds_vc_status (ds_vc_status),
        .err_drop     (err_drop),
        .tx_count     (tx_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] vc, input logic [63:0] flit);
        exp_t e;
        e.vc   = vc;
        e.flit = flit;
        sb.push_back(e);
    endtask

    task automatic send(input logic [1:0] vc, input logic [63:0] flit);
        in_valid = 1'b1;
        in_vc    = vc;
        in_flit  = flit;
        tick();
        in_valid = 1'b0;
    endtask

    // Link monitor: every flit on the link must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && tx_valid) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_tx actual vc=%0d flit=%0h expected none", tx_vc, tx_flit);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_vc", {62'd0, tx_vc}, {62'd0, e.vc});
                chk("mon_flit", tx_flit, e.flit);
            end
        end
    end

    // Watchdog keeps the run bounded.
    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b1; in_vc = 2'd0; in_flit = 64'hFF; ds_vc_status = 2'b11;

        // 1 reset with in_valid held high
        repeat (3) tick();
        @(negedge clk);
        chk("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
        chk("rst_ready", {62'd0, in_vc_ready}, 64'd3);
        chk("rst_tx_count", {48'd0, tx_count}, 64'd0);
        chk("rst_err_drop", {63'd0, err_drop}, 64'd0);
        tick();
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_empty", {63'd0, tx_valid}, 64'd0);
        tick();

        // 2 single flit
        push(2'd0, 64'hA5);
        send(2'd0, 64'hA5);
        @(negedge clk);
        chk("single_valid", {63'd0, tx_valid}, 64'd1);
        chk("single_vc", {62'd0, tx_vc}, 64'd0);
        chk("single_flit", tx_flit, 64'hA5);
        tick();
        @(negedge clk);
        chk("single_count", {48'd0, tx_count}, 64'd1);
        chk("single_idle", {63'd0, tx_valid}, 64'd0);
        tick();

        // 3 backpressure, overflow drop, release in order
        ds_vc_status = 2'b00;
        send(2'd0, 64'hB1);
        send(2'd0, 64'hB2);
        @(negedge clk);
        chk("bp_ready", {62'd0, in_vc_ready}, 64'd2);
        chk("bp_hold", {63'd0, tx_valid}, 64'd0);
        tick();
        send(2'd0, 64'hB3);
        @(negedge clk);
        chk("bp_drop", {63'd0, err_drop}, 64'd1);
        chk("bp_hold2", {63'd0, tx_valid}, 64'd0);
        tick();
        @(negedge clk);
        chk("bp_drop_pulse", {63'd0, err_drop}, 64'd0);
        tick();
        ds_vc_status = 2'b01;
        push(2'd0, 64'hB1);
        push(2'd0, 64'hB2);
        @(negedge clk);
        chk("bp_first", tx_flit, 64'hB1);
        tick();
        @(negedge clk);
        chk("bp_second", tx_flit, 64'hB2);
        tick();
        @(negedge clk);
        chk("bp_done", {63'd0, tx_valid}, 64'd0);
        chk("bp_count", {48'd0, tx_count}, 64'd3);
        tick();

        // one VC1 flit so VC0 wins the next tie
        ds_vc_status = 2'b11;
        push(2'd1, 64'hE1);
        send(2'd1, 64'hE1);
        @(negedge clk);
        chk("e1_vc", {62'd0, tx_vc}, 64'd1);
        tick();

        // 4 fairness
        ds_vc_status = 2'b00;
        send(2'd0, 64'hC1);
        send(2'd0, 64'hC2);
        send(2'd1, 64'hD1);
        send(2'd1, 64'hD2);
        ds_vc_status = 2'b11;
        push(2'd0, 64'hC1); push(2'd1, 64'hD1);
        push(2'd0, 64'hC2); push(2'd1, 64'hD2);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("rr_vc", {62'd0, tx_vc}, (i % 2 == 0) ? 64'd0 : 64'd1);
            tick();
        end
        @(negedge clk);
        chk("rr_count", {48'd0, tx_count}, 64'd8);
        tick();

        // 5 isolation
        ds_vc_status = 2'b00;
        send(2'd0, 64'hF1);
        send(2'd0, 64'hF2);
        send(2'd1, 64'h61);
        send(2'd1, 64'h62);
        ds_vc_status = 2'b01;
        push(2'd0, 64'hF1); push(2'd0, 64'hF2);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("iso_vc0", {62'd0, tx_vc}, 64'd0);
            tick();
        end
        @(negedge clk);
        chk("iso_held", {63'd0, tx_valid}, 64'd0);
        chk("iso_ready", {62'd0, in_vc_ready}, 64'd1);
        tick();
        ds_vc_status = 2'b10;
        push(2'd1, 64'h61); push(2'd1, 64'h62);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("iso_vc1", {62'd0, tx_vc}, 64'd1);
            tick();
        end
        @(negedge clk);
        chk("iso_count", {48'd0, tx_count}, 64'd12);
        tick();

        // 6a out-of-range VC ids
        in_valid = 1'b1; in_vc = 2'd2; in_flit = 64'hDEAD;
        tick();
        in_vc = 2'd3;
        @(negedge clk);
        chk("badvc2_drop", {63'd0, err_drop}, 64'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("badvc3_drop", {63'd0, err_drop}, 64'd1);
        tick();
        @(negedge clk);
        chk("badvc_clear", {63'd0, err_drop}, 64'd0);
        chk("badvc_ready", {62'd0, in_vc_ready}, 64'd3);
        chk("badvc_none", {63'd0, tx_valid}, 64'd0);
        tick();

        // 6b enqueue+dequeue at count==1, then on a full queue
        ds_vc_status = 2'b00;
        send(2'd0, 64'h11);
        ds_vc_status = 2'b01;
        in_valid = 1'b1; in_vc = 2'd0; in_flit = 64'h12;
        push(2'd0, 64'h11); push(2'd0, 64'h12);
        @(negedge clk);
        chk("ed_head", tx_flit, 64'h11);
        tick();
        in_valid = 1'b0;
        ds_vc_status = 2'b00;
        @(negedge clk);
        chk("ed_ready", {62'd0, in_vc_ready}, 64'd3);
        chk("ed_no_drop", {63'd0, err_drop}, 64'd0);
        tick();
        send(2'd0, 64'h13);
        @(negedge clk);
        chk("ed_full", {62'd0, in_vc_ready}, 64'd2);
        tick();
        ds_vc_status = 2'b01;
        in_valid = 1'b1; in_vc = 2'd0; in_flit = 64'h14;
        push(2'd0, 64'h13);
        @(negedge clk);
        chk("full_head", tx_flit, 64'h12);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_drop", {63'd0, err_drop}, 64'd1);
        chk("full_next", tx_flit, 64'h13);
        chk("full_ready", {62'd0, in_vc_ready}, 64'd3);
        tick();
        @(negedge clk);
        chk("full_empty", {63'd0, tx_valid}, 64'd0);
        chk("full_count", {48'd0, tx_count}, 64'd15);
        tick();

        // 6c stream to 0xFFFF, then wrap
        ds_vc_status = 2'b11;
        for (int i = 0; i < 65520; i++) begin
            in_valid = 1'b1; in_vc = 2'd0; in_flit = 64'h1000_0000 + 64'(i);
            push(2'd0, 64'h1000_0000 + 64'(i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("cnt_ffff", {48'd0, tx_count}, 64'hFFFF);
        chk("cnt_idle", {63'd0, tx_valid}, 64'd0);
        tick();
        push(2'd0, 64'h77);
        send(2'd0, 64'h77);
        tick();
        @(negedge clk);
        chk("cnt_wrap", {48'd0, tx_count}, 64'd0);
        tick();

        // 6d reset mid-stream discards queued flits
        ds_vc_status = 2'b00;
        send(2'd0, 64'h81);
        send(2'd0, 64'h82);
        send(2'd1, 64'h91);
        ds_vc_status = 2'b11;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_valid", {63'd0, tx_valid}, 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mrst_empty", {63'd0, tx_valid}, 64'd0);
        chk("mrst_ready", {62'd0, in_vc_ready}, 64'd3);
        chk("mrst_count", {48'd0, tx_count}, 64'd0);
        tick();
        tick();
        @(negedge clk);
        chk("mrst_still_empty", {63'd0, tx_valid}, 64'd0);
        chk("sb_drained", 64'(sb.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
